// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the core, loader and memory-side signals of the data memory port arbiter.
// The arbiter takes the slave view; a requester/memory model takes the master view.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic              ldr_lock;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_gnt;
  logic              ldr_rvalid;
  logic [DATA_W-1:0] ldr_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_rvalid, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output ldr_req, ldr_we, ldr_lock, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_rvalid, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core and the loader,
// with a bounded loader lock and one-cycle tagged read return.
module dmem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmem_port_arbiter_if.slave   bus
);
  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  logic              r_run;
  logic              r_last_win;
  logic [3:0]        r_burst_cnt;
  logic [1:0]        r_rd_owner;

  logic              w_core_gnt;
  logic              w_ldr_gnt;
  logic              w_lock_hold;
  logic [3:0]        w_burst_nxt;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  // Grant decision; r_run keeps grants off until rst_n has been sampled high once.
  always_comb begin
    w_core_gnt  = 1'b0;
    w_ldr_gnt   = 1'b0;
    w_lock_hold = bus.ldr_lock && r_last_win && (r_burst_cnt < BURST_LIMIT);
    if (rst_n && r_run) begin
      case ({bus.core_req, bus.ldr_req})
        2'b10: w_core_gnt = 1'b1;
        2'b01: w_ldr_gnt  = 1'b1;
        2'b11: begin
          if (w_lock_hold) begin
            w_ldr_gnt = 1'b1;
          end else if (r_last_win) begin
            w_core_gnt = 1'b1;
          end else begin
            w_ldr_gnt = 1'b1;
          end
        end
        default: begin
          w_core_gnt = 1'b0;
          w_ldr_gnt  = 1'b0;
        end
      endcase
    end else begin
      w_core_gnt = 1'b0;
      w_ldr_gnt  = 1'b0;
    end
  end

  // Burst counter only advances on locked loader grants that the core is contending for.
  always_comb begin
    w_burst_nxt = 4'd0;
    if (w_ldr_gnt && bus.ldr_lock) begin
      if (bus.core_req && (r_burst_cnt < BURST_LIMIT)) begin
        w_burst_nxt = r_burst_cnt + 4'd1;
      end else begin
        w_burst_nxt = r_burst_cnt;
      end
    end else begin
      w_burst_nxt = 4'd0;
    end
  end

  // Memory port mux from the granted requester.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = {ADDR_W{1'b0}};
    w_mem_wdata = {DATA_W{1'b0}};
    if (w_core_gnt) begin
      w_mem_we    = bus.core_we;
      w_mem_addr  = bus.core_addr;
      w_mem_wdata = bus.core_wdata;
    end else if (w_ldr_gnt) begin
      w_mem_we    = bus.ldr_we;
      w_mem_addr  = bus.ldr_addr;
      w_mem_wdata = bus.ldr_wdata;
    end else begin
      w_mem_we    = 1'b0;
      w_mem_addr  = {ADDR_W{1'b0}};
      w_mem_wdata = {DATA_W{1'b0}};
    end
  end

  // Arbitration history, burst count and read-return owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run       <= 1'b0;
      r_last_win  <= 1'b1;
      r_burst_cnt <= 4'd0;
      r_rd_owner  <= 2'b00;
    end else begin
      r_run <= 1'b1;
      if (w_core_gnt) begin
        r_last_win <= 1'b0;
      end else if (w_ldr_gnt) begin
        r_last_win <= 1'b1;
      end else begin
        r_last_win <= r_last_win;
      end
      r_burst_cnt <= w_burst_nxt;
      r_rd_owner  <= {w_ldr_gnt & ~bus.ldr_we, w_core_gnt & ~bus.core_we};
    end
  end

  assign bus.core_gnt    = w_core_gnt;
  assign bus.ldr_gnt     = w_ldr_gnt;
  assign bus.mem_en      = w_core_gnt | w_ldr_gnt;
  assign bus.mem_we      = w_mem_we;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_wdata   = w_mem_wdata;

  // Return data is steered to the owner only; the idle side sees zero.
  assign bus.core_rvalid = r_rd_owner[0];
  assign bus.ldr_rvalid  = r_rd_owner[1];
  assign bus.core_rdata  = r_rd_owner[0] ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.ldr_rdata   = r_rd_owner[1] ? bus.mem_rdata : {DATA_W{1'b0}};
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path (core_*) and a memory loader/debug port (ldr_*).
- Grants at most one access per cycle and issues it to the memory port in the same cycle.
- Returns read data one cycle later, tagged to the requester that issued the read.
- Arbitration is round-robin. The loader may lock the port for a bounded burst, used for program/data preload.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_BURST, 4, maximum consecutive locked loader grants while the core is also requesting (1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- core_req  in  1  core access request.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  core byte address.
- core_wdata  in  DATA_W  core write data.
- core_gnt  out  1  core request accepted this cycle.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DATA_W  core read data.
- ldr_req  in  1  loader request.
- ldr_we  in  1  loader write enable.
- ldr_lock  in  1  loader asks to keep ownership.
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  DATA_W  loader write data.
- ldr_gnt  out  1  loader request accepted this cycle.
- ldr_rvalid  out  1  loader read data valid.
- ldr_rdata  out  DATA_W  loader read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe.

Behaviour:
- Handshake: a request is accepted in the cycle where req=1 and gnt=1.
  - A requester holds req/we/addr/wdata stable until granted.
  - gnt is combinational from req and registered state. It never depends on mem_rdata.
- Issue: mem_en = core_gnt | ldr_gnt. mem_we/addr/wdata are muxed from the granted requester. With no grant, mem_en=0, mem_we=0, and addr/wdata are don't-care (driven 0).
- Single request: the lone requester is granted the same cycle.
- Both request, no lock: the requester not granted most recently wins.
  - Register last_win (0 = core, 1 = loader) updates on every accepted access.
- Lock: while ldr_lock=1 and last_win=loader, the loader keeps priority.
  - burst_cnt counts consecutive locked loader grants taken while core_req=1.
  - When burst_cnt reaches MAX_BURST and core_req=1, the next contested cycle goes to the core and burst_cnt clears.
  - burst_cnt also clears on any core grant, on ldr_lock=0, or on a cycle with no grant.
  - Cycles where core_req=0 do not increment burst_cnt.
- Read return: register rd_owner (2-bit one-hot, or none) is set on an accepted read.
  - Next cycle, the owner's rvalid=1 for exactly one cycle and its rdata = mem_rdata.
  - The other requester's rdata is 0.
- Writes never produce rvalid.
- Back-to-back reads are allowed, one per cycle. A grant in cycle N and a return in N+1 may overlap a new grant in N+1.
- Reset (rst_n low, asynchronous):
  - core_gnt=ldr_gnt=0, mem_en=0, mem_we=0.
  - core_rvalid=ldr_rvalid=0, rdata outputs 0.
  - last_win=loader, so the core wins the first contest; burst_cnt=0, rd_owner=none.
  - Grants are forced 0 while rst_n=0.
- Reset mid-read: a read granted in the cycle before reset assertion produces no rvalid. The pending return is discarded.
- Reset release: first grant possible in the first cycle after rst_n is sampled high.

Test Plan:
- Reset: hold rst_n=0 with both requests high -> gnt=0, mem_en=0, rvalid=0. After release with both reading, core granted first, then loader.
- Core-only read: core_req=1, addr=0x10, mem returns 0xDEADBEEF -> core_gnt=1 and mem_en=1 in cycle N; core_rvalid=1 and core_rdata=0xDEADBEEF in N+1 only; ldr_rvalid stays 0.
- Contention: both read continuously for 6 cycles, no lock -> grants alternate C,L,C,L,C,L; each rvalid routed to the correct owner one cycle after its grant.
- Locked burst: MAX_BURST=4; loader wins with ldr_lock=1 while core requests -> loader granted 4 consecutive locked cycles, then core granted, then loader resumes.
- Write: ldr_we=1, addr=0x20, wdata=0x12345678 -> mem_en=1, mem_we=1, mem_addr=0x20, mem_wdata=0x12345678 in the grant cycle; no rvalid next cycle.
- Reset mid-read: core read granted in cycle N, rst_n asserted low in N+1 before the edge -> core_rvalid never asserts and all outputs reach their reset values immediately.
